// File: rtl/seq_add_32bit.sv
// Multi-cycle adder: one (N+1)-bit slice per clock, LSB slice first, fixed latency.
// Optional subtract mode (A + ~B + 1) when macro SEQ_ADD_SUB_EN is defined.
module seq_add_32bit #(
  parameter int unsigned N      = 7,
  parameter int unsigned SLICES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [SLICES*(N+1)-1:0]   A,
  input  logic [SLICES*(N+1)-1:0]   B,
  input  logic                      Cin,
  input  logic                      sub,
  output logic                      busy,
  output logic                      done,
  output logic [SLICES*(N+1)-1:0]   S,
  output logic                      Cout
);

  localparam int unsigned SW = N + 1;
  localparam int unsigned W  = SLICES * SW;
  localparam int unsigned IW = (SLICES > 1) ? $clog2(SLICES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_load;
  logic            w_step;
  logic            w_last;

  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_carry;
  logic [IW-1:0]   r_idx;
  logic [W-1:0]    r_s;
  logic            r_cout;
  logic            r_busy;
  logic            r_done;

  logic [W-1:0]    w_b_in;
  logic            w_cin_in;
  logic [SW-1:0]   w_a_slice;
  logic [SW-1:0]   w_b_slice;
  logic [SW:0]     w_sum;

  // Operand conditioning applied once, at capture time.
`ifdef SEQ_ADD_SUB_EN
  assign w_b_in   = sub ? ~B : B;
  assign w_cin_in = sub ? 1'b1 : Cin;
`else
  logic w_unused_sub;
  assign w_unused_sub = sub;
  assign w_b_in       = B;
  assign w_cin_in     = Cin;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath strobes
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_step = 1'b1;
        if (r_idx == IW'(SLICES - 1)) begin
          w_last      = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Select the active slice and add it with the registered carry
  always_comb begin
    w_a_slice = '0;
    w_b_slice = '0;
    for (int i = 0; i < SLICES; i++) begin
      if (r_idx == IW'(i)) begin
        w_a_slice = r_a[i*SW +: SW];
        w_b_slice = r_b[i*SW +: SW];
      end
    end
    w_sum = {1'b0, w_a_slice} + {1'b0, w_b_slice} + (SW+1)'(r_carry);
  end

  // Operand capture, slice accumulation and carry chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_s     <= '0;
      r_cout  <= 1'b0;
    end else if (w_load) begin
      r_a     <= A;
      r_b     <= w_b_in;
      r_carry <= w_cin_in;
      r_idx   <= '0;
    end else if (w_step) begin
      for (int i = 0; i < SLICES; i++) begin
        if (r_idx == IW'(i)) begin
          r_s[i*SW +: SW] <= w_sum[SW-1:0];
        end
      end
      r_carry <= w_sum[SW];
      if (w_last) begin
        r_cout <= w_sum[SW];
        r_idx  <= '0;
      end else begin
        r_idx  <= r_idx + IW'(1);
      end
    end
  end

  // Status flags registered from the next state so they align with it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == RUN);
      r_done <= (w_state_nxt == DONE);
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign S    = r_s;
  assign Cout = r_cout;

endmodule

// File: tb/tb_seq_add_32bit.sv
// Self-checking bench for seq_add_32bit: directed corner cases plus random regression
// against an arithmetic reference model.
module tb_seq_add_32bit;

  localparam int unsigned N      = 7;
  localparam int unsigned SLICES = 4;
  localparam int unsigned W      = SLICES * (N + 1);
`ifdef SEQ_ADD_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic          Cin;
  logic          sub;
  logic          busy;
  logic          done;
  logic [W-1:0]  S;
  logic          Cout;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  seq_add_32bit #(.N(N), .SLICES(SLICES)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .sub   (sub),
    .busy  (busy),
    .done  (done),
    .S     (S),
    .Cout  (Cout)
  );

  always @(posedge clk) begin
    if (done === 1'b1) done_cnt++;
  end

  function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c, input logic s);
    if (SUB_EN && s) return {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    return {1'b0, a} + {1'b0, b} + (W+1)'(c);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One accepted operation: latency, busy, result and post-done stability.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic s, input string tag, input int hold);
    logic [W:0] e;
    int lat;
    e = ref_sum(a, b, c, s);
    @(negedge clk);
    A = a; B = b; Cin = c; sub = s; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    A = $urandom; B = $urandom; Cin = 1'($urandom); sub = 1'($urandom);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) chk({tag, " busy"}, 64'(busy), 64'(1));
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
    chk({tag, " latency"}, 64'(lat), 64'(SLICES + 1));
    chk({tag, " S"}, 64'(S), 64'(e[W-1:0]));
    chk({tag, " Cout"}, 64'(Cout), 64'(e[W]));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      if (k == 0) chk({tag, " done pulse width"}, 64'(done), 64'(0));
    end
    if (hold > 0) begin
      chk({tag, " S stable"}, 64'(S), 64'(e[W-1:0]));
      chk({tag, " Cout stable"}, 64'(Cout), 64'(e[W]));
    end
  endtask

  initial begin
    int dc0;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    rst = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0; sub = 1'b0;
    #2;
    chk("reset busy", 64'(busy), 64'(0));
    chk("reset done", 64'(done), 64'(0));
    chk("reset S", 64'(S), 64'(0));
    chk("reset Cout", 64'(Cout), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // Carry ripples across a slice boundary
    run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, "ripple", 2);
    chk("ripple S const", 64'(S), 64'h0000_0100);
    chk("ripple Cout const", 64'(Cout), 64'(0));

    // Full wrap through every slice
    run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, "wrap", 1);
    chk("wrap S const", 64'(S), 64'h0);
    chk("wrap Cout const", 64'(Cout), 64'(1));

    // Subtract request: honoured only when the option is built in
    run_op(32'd5, 32'd7, 1'b0, 1'b1, "sub", 1);
    chk("sub S const", 64'(S), SUB_EN ? 64'hFFFF_FFFE : 64'd12);
    chk("sub Cout const", 64'(Cout), 64'(0));

    // Start while busy must be ignored
    @(negedge clk);
    A = 32'h1234_5678; B = 32'h0101_0101; Cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    dc0 = done_cnt;
    @(negedge clk);
    @(negedge clk);
    A = 32'hFFFF_0000; B = 32'h0F0F_0F0F; Cin = 1'b1; sub = 1'b1; start = 1'b1;
    chk("ignored start busy", 64'(busy), 64'(1));
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    chk("ignored start S", 64'(S), 64'h1335_5779);
    chk("ignored start Cout", 64'(Cout), 64'(0));
    chk("ignored start done count", 64'(done_cnt - dc0), 64'(1));

    // Reset in the second RUN cycle aborts with no done
    @(negedge clk);
    A = 32'hDEAD_BEEF; B = 32'h1111_1111; Cin = 1'b1; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    dc0 = done_cnt;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort busy", 64'(busy), 64'(0));
    chk("abort done", 64'(done), 64'(0));
    chk("abort S", 64'(S), 64'h0);
    chk("abort Cout", 64'(Cout), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort no done", 64'(done_cnt - dc0), 64'(0));
    run_op(32'd1, 32'd2, 1'b0, 1'b0, "after abort", 1);
    chk("after abort S const", 64'(S), 64'd3);

    // Random regression
    dc0 = done_cnt;
    for (int n = 0; n < 1000; n++) begin
      ra = $urandom;
      rb = $urandom;
      if (n % 8 == 0) rb = ~ra;
      run_op(ra, rb, 1'($urandom), 1'($urandom), "random", int'($urandom_range(1, 3)));
    end
    repeat (2) @(negedge clk);
    chk("random done count", 64'(done_cnt - dc0), 64'(1000));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
